// File: rtl/mips_mem_resp_if.sv
// Request/response handshake bus between a MIPS pipeline and its data/instruction memory.
interface mips_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Processor side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mips_mem_resp.sv
// Single-outstanding memory responder for a MIPS core: accepts one word load/store,
// inserts WAIT_CYCLES wait states, performs the access, then holds the response
// until the processor takes it. Out-of-range addresses answer with resp_err.
module mips_mem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk1,
  input  logic                   reset,
  mips_mem_resp_if.slave         bus,
  output logic                   busy,
  output logic [15:0]            acc_cnt
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Saturating increment for the completed-handshake counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] acc_cnt_q, acc_cnt_d;

  logic [31:0] mem [0:DEPTH-1];

  logic             accept;
  logic             resp_hs;
  logic             enter_resp;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_rdata;
  logic             mem_wr;

  // Handshake qualifiers and the RESP-entry strobe that triggers the memory access.
  always_comb begin
    accept     = bus.req_valid && (state_q == ST_IDLE);
    resp_hs    = bus.resp_ready && (state_q == ST_RESP);
    enter_resp = 1'b0;
    if (state_q == ST_IDLE && accept && NO_WAIT) begin
      enter_resp = 1'b1;
    end else if (state_q == ST_WAIT && wait_cnt_q <= 4'd1) begin
      enter_resp = 1'b1;
    end
  end

  // With no wait states the access happens on the accept edge itself, before the
  // request registers are loaded, so the access path takes the live bus fields then.
  always_comb begin
    acc_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    in_range  = (acc_addr < 32'(DEPTH));
    idx       = acc_addr[IDX_W-1:0];
    mem_rdata = mem[idx];
    // Reset wins over a pending store, so an aborted access never reaches memory.
    mem_wr    = enter_resp && in_range && acc_we && !reset;
  end

  // Next-state, wait counter, response data and handshake counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    acc_cnt_d  = acc_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (NO_WAIT) begin
            state_d    = ST_RESP;
            wait_cnt_d = 4'd0;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          wait_cnt_d = 4'd0;
        end
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_d   = ST_IDLE;
          rdata_d   = 32'd0;
          err_d     = 1'b0;
          acc_cnt_d = sat_inc16(acc_cnt_q);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase

    // Stores and faulting accesses return zero data; only in-range loads read memory.
    if (enter_resp) begin
      rdata_d = (in_range && !acc_we) ? mem_rdata : 32'd0;
      err_d   = !in_range;
    end
  end

  // Control and response registers; reset has priority over every handshake.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      acc_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  // Captured request fields; only meaningful while a request is in flight.
  always_ff @(posedge clk1) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Backing store; contents survive reset.
  always_ff @(posedge clk1) begin
    if (mem_wr) begin
      mem[idx] <= acc_wdata;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    busy           = (state_q != ST_IDLE);
    acc_cnt        = acc_cnt_q;
  end

endmodule

// File: tb/tb_mips_mem_resp.sv
// Bench for mips_mem_resp: DUT A (DEPTH=1024, WAIT_CYCLES=2) carries the directed and
// random scenarios, DUT B (DEPTH=64, WAIT_CYCLES=0) carries the back-to-back stream.
module tb_mips_mem_resp;

  localparam int DEPTH_A = 1024;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 64;
  localparam int WAIT_B  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy_a, busy_b;
  logic [15:0] acc_cnt_a, acc_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_a = 0;
  int acc_b = 0;
  logic [31:0] ref_a [int];
  logic [31:0] ref_b [int];

  always #5 clk = ~clk;

  mips_mem_resp_if bus_a ();
  mips_mem_resp_if bus_b ();

  mips_mem_resp #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk1(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .acc_cnt(acc_cnt_a)
  );

  mips_mem_resp #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk1(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .acc_cnt(acc_cnt_b)
  );

  // One complete transaction on bus A; lat counts edges from the accept edge (inclusive)
  // to the edge after which resp_valid is seen. Call at #1 after a rising edge.
  task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rdata, output logic err,
                       output int lat, output bit ok);
    int t;
    ok = 1'b0; rdata = '0; err = 1'b0; lat = 0;
    bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    bus_a.req_valid = 1'b1;
    t = 0;
    while (!bus_a.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus_a.req_ready) begin bus_a.req_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (!bus_a.resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!bus_a.resp_valid) return;
    rdata = bus_a.resp_rdata;
    err   = bus_a.resp_err;
    repeat (hold) begin @(posedge clk); #1; end
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_a.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus_a.req_ready); end
    n_cmp++; if (bus_a.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus_a.resp_valid); end
    n_cmp++; if (bus_a.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus_a.resp_rdata); end
    n_cmp++; if (bus_a.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus_a.resp_err); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (acc_cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_acc_cnt: got %0d want 0", acc_cnt_a); end
    n_cmp++; if (bus_b.req_ready !== 1'b1 || busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_b: got ready=%b busy=%b want 1/0", bus_b.req_ready, busy_b); end
    // A request presented while reset is high must not be taken.
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 32'd3;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_priority_busy: got %b want 0", busy_a); end
    bus_a.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy_a); end
    acc_a = 0; acc_b = 0;
  endtask

  task automatic test_store_latency();
    logic [31:0] rd; logic er; int lat; bit ok;
    run_a(1'b1, 32'd5, 32'hDEADBEEF, 0, rd, er, lat, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL store5_timeout: got no handshake want handshake"); end
    ref_a[5] = 32'hDEADBEEF; acc_a++;
    n_cmp++; if (lat != 1 + WAIT_A) begin n_bad++; $display("FAIL store5_latency: got %0d want %0d", lat, 1 + WAIT_A); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store5_err: got %b want 0", er); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL store5_rdata: got %h want 0", rd); end
    n_cmp++; if (acc_cnt_a !== 16'(acc_a)) begin n_bad++; $display("FAIL store5_acc_cnt: got %0d want %0d", acc_cnt_a, acc_a); end
  endtask

  task automatic test_load_raw();
    logic [31:0] rd; logic er; int lat; bit ok;
    run_a(1'b0, 32'd5, 32'h0, 1, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || rd !== ref_a[5]) begin n_bad++; $display("FAIL load5_rdata: got %h want %h", rd, ref_a[5]); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL load5_err: got %b want 0", er); end
    n_cmp++; if (acc_cnt_a !== 16'(acc_a)) begin n_bad++; $display("FAIL load5_acc_cnt: got %0d want %0d", acc_cnt_a, acc_a); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; bit ok;
    run_a(1'b1, 32'd0, 32'hA5A5_0000, 0, rd, er, lat, ok);
    ref_a[0] = 32'hA5A5_0000; acc_a++;
    run_a(1'b0, 32'd1024, 32'h0, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || er !== 1'b1) begin n_bad++; $display("FAIL oob_load_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oob_load_rdata: got %h want 0", rd); end
    // A store beyond the array must not alias onto word 0.
    run_a(1'b1, 32'd1024, 32'h0BAD_0BAD, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || er !== 1'b1) begin n_bad++; $display("FAIL oob_store_err: got %b want 1", er); end
    run_a(1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || er !== 1'b1) begin n_bad++; $display("FAIL oob_store_top_err: got %b want 1", er); end
    run_a(1'b0, 32'd0, 32'h0, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || rd !== ref_a[0]) begin n_bad++; $display("FAIL oob_mem_unchanged: got %h want %h", rd, ref_a[0]); end
    n_cmp++; if (acc_cnt_a !== 16'(acc_a)) begin n_bad++; $display("FAIL oob_acc_cnt: got %0d want %0d", acc_cnt_a, acc_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0; int t;
    bus_a.req_we = 1'b0; bus_a.req_addr = 32'd5; bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    t = 0;
    while (!bus_a.resp_valid && t < 40) begin @(posedge clk); #1; t++; end
    n_cmp++; if (bus_a.resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resp_timeout: got %b want 1", bus_a.resp_valid); end
    r0 = bus_a.resp_rdata;
    n_cmp++; if (r0 !== ref_a[5]) begin n_bad++; $display("FAIL bp_rdata: got %h want %h", r0, ref_a[5]); end
    // A competing request during the stall must be ignored, not queued.
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 32'd6; bus_a.req_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== r0) begin n_bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h want v=1 d=%h", i, bus_a.resp_valid, bus_a.resp_rdata, r0); end
      n_cmp++; if (bus_a.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low_%0d: got %b want 0", i, bus_a.req_ready); end
    end
    bus_a.req_valid = 1'b0;
    bus_a.resp_ready = 1'b1;
    #1;
    n_cmp++; if (bus_a.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_turnaround: got %b want 0", bus_a.req_ready); end
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
    acc_a++;
    n_cmp++; if (bus_a.req_ready !== 1'b1 || bus_a.resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", bus_a.req_ready, bus_a.resp_valid); end
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL bp_no_queue: got busy=%b want 0", busy_a); end
    n_cmp++; if (acc_cnt_a !== 16'(acc_a)) begin n_bad++; $display("FAIL bp_acc_cnt: got %0d want %0d", acc_cnt_a, acc_a); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat; bit ok; int t;
    run_a(1'b1, 32'd7, 32'h1111_2222, 0, rd, er, lat, ok);
    ref_a[7] = 32'h1111_2222; acc_a++;
    // Store accepted, then reset on the following edge while still waiting.
    bus_a.req_we = 1'b1; bus_a.req_addr = 32'd7; bus_a.req_wdata = 32'h0000_1234; bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rstwait_accepted: got busy=%b want 1", busy_a); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    acc_a = 0; acc_b = 0;
    n_cmp++; if (busy_a !== 1'b0 || bus_a.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstwait_abort: got busy=%b valid=%b want 0/0", busy_a, bus_a.resp_valid); end
    n_cmp++; if (acc_cnt_a !== 16'd0) begin n_bad++; $display("FAIL rstwait_acc_cnt: got %0d want 0", acc_cnt_a); end
    run_a(1'b0, 32'd7, 32'h0, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || rd !== ref_a[7]) begin n_bad++; $display("FAIL rstwait_no_write: got %h want %h", rd, ref_a[7]); end
    // Store reaches RESP (already committed), then reset discards the response.
    bus_a.req_we = 1'b1; bus_a.req_addr = 32'd9; bus_a.req_wdata = 32'hCAFE_F00D; bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    t = 0;
    while (!bus_a.resp_valid && t < 40) begin @(posedge clk); #1; t++; end
    ref_a[9] = 32'hCAFE_F00D;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    acc_a = 0; acc_b = 0;
    n_cmp++; if (bus_a.resp_valid !== 1'b0 || acc_cnt_a !== 16'd0) begin n_bad++; $display("FAIL rstresp_discard: got valid=%b acc=%0d want 0/0", bus_a.resp_valid, acc_cnt_a); end
    run_a(1'b0, 32'd9, 32'h0, 0, rd, er, lat, ok);
    acc_a++;
    n_cmp++; if (!ok || rd !== ref_a[9]) begin n_bad++; $display("FAIL rstresp_committed: got %h want %h", rd, ref_a[9]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd; logic er, we, exp_er; int lat, hold, r; bit ok;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      addr = 32'($urandom_range(0, 15));
      else if (r < 9) addr = 32'(DEPTH_A + $urandom_range(0, 100));
      else            addr = $urandom | 32'h8000_0000;
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      if (!we && addr < DEPTH_A && !ref_a.exists(int'(addr))) we = 1'b1;
      exp_er = (addr >= DEPTH_A);
      exp_rd = (!we && !exp_er) ? ref_a[int'(addr)] : 32'd0;
      if (we && !exp_er) ref_a[int'(addr)] = wd;
      run_a(we, addr, wd, hold, rd, er, lat, ok);
      acc_a++;
      n_cmp++; if (!ok || rd !== exp_rd || er !== exp_er) begin n_bad++; $display("FAIL rand_%0d: got ok=%b d=%h e=%b want d=%h e=%b (we=%b a=%h)", i, ok, rd, er, exp_rd, exp_er, we, addr); end
      n_cmp++; if (lat != 1 + WAIT_A) begin n_bad++; $display("FAIL rand_lat_%0d: got %0d want %0d", i, lat, 1 + WAIT_A); end
      n_cmp++; if (acc_cnt_a !== 16'(acc_a)) begin n_bad++; $display("FAIL rand_acc_%0d: got %0d want %0d", i, acc_cnt_a, acc_a); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic        tx_we   [N];
    logic [31:0] tx_addr [N];
    logic [31:0] tx_data [N];
    logic [31:0] exp_rd; logic exp_er;
    int idx, cyc, last_acc;
    bit will_acc;
    for (int i = 0; i < N; i++) begin
      tx_we[i]   = (i < 5);
      tx_data[i] = $urandom;
    end
    tx_addr[0] = 32'd3;  tx_addr[1] = 32'd10; tx_addr[2]  = 32'd63; tx_addr[3]  = 32'd64;
    tx_addr[4] = 32'd20; tx_addr[5] = 32'd3;  tx_addr[6]  = 32'd10; tx_addr[7]  = 32'd63;
    tx_addr[8] = 32'd64; tx_addr[9] = 32'd20; tx_addr[10] = 32'd200; tx_addr[11] = 32'd3;
    idx = 0; cyc = 0; last_acc = -1;
    bus_b.resp_ready = 1'b1;
    bus_b.req_we = tx_we[0]; bus_b.req_addr = tx_addr[0]; bus_b.req_wdata = tx_data[0];
    bus_b.req_valid = 1'b1;
    while (idx < N && cyc < 200) begin
      will_acc = bus_b.req_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        exp_er = (tx_addr[idx] >= DEPTH_B);
        exp_rd = (!tx_we[idx] && !exp_er) ? ref_b[int'(tx_addr[idx])] : 32'd0;
        if (tx_we[idx] && !exp_er) ref_b[int'(tx_addr[idx])] = tx_data[idx];
        acc_b++;
        n_cmp++; if (bus_b.resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_%0d: got %b want 1", idx, bus_b.resp_valid); end
        n_cmp++; if (bus_b.resp_rdata !== exp_rd || bus_b.resp_err !== exp_er) begin n_bad++; $display("FAIL b2b_data_%0d: got d=%h e=%b want d=%h e=%b", idx, bus_b.resp_rdata, bus_b.resp_err, exp_rd, exp_er); end
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc != 2) begin n_bad++; $display("FAIL b2b_spacing_%0d: got %0d want 2", idx, cyc - last_acc); end
        end
        last_acc = cyc;
        idx++;
        if (idx < N) begin
          bus_b.req_we = tx_we[idx]; bus_b.req_addr = tx_addr[idx]; bus_b.req_wdata = tx_data[idx];
        end
      end else begin
        n_cmp++; if (bus_b.resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_%0d: got %b want 0", idx, bus_b.resp_valid); end
      end
    end
    bus_b.req_valid = 1'b0;
    n_cmp++; if (idx != N) begin n_bad++; $display("FAIL b2b_timeout: got %0d accepts want %0d", idx, N); end
    @(posedge clk); #1;
    bus_b.resp_ready = 1'b0;
    n_cmp++; if (acc_cnt_b !== 16'(acc_b) || busy_b !== 1'b0) begin n_bad++; $display("FAIL b2b_final: got acc=%0d busy=%b want %0d/0", acc_cnt_b, busy_b, acc_b); end
  endtask

  initial begin
    test_reset();
    test_store_latency();
    test_load_raw();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_resp.md
MIPS_MEM_RESP -- requirements
Module: mips_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the backing store (power of two, at most 1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request accept and the memory access (legal range 0..15).
REQ-003 SHALL have port clk1, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the processor presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store (SW), 0 = load (LW) or instruction fetch.
REQ-008 SHALL have port req_addr, input, 32 bits: word address (EX_MEM_ALUOut or PC).
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: response available.
REQ-011 SHALL have port resp_ready, input, 1 bit: the processor accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load data.
REQ-013 SHALL have port resp_err, output, 1 bit: the address was out of range.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-015 SHALL have port acc_cnt, output, 16 bits: count of completed response handshakes.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on any edge where req_valid & req_ready, and register we, addr, and wdata on that edge.
REQ-018 SHALL, on accept, go IDLE->WAIT with a 4-bit wait counter loaded with WAIT_CYCLES; if WAIT_CYCLES=0, SHALL go IDLE->RESP directly.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter is 1.
REQ-020 SHALL perform the memory access on the edge that enters RESP, so resp_valid rises exactly 1+WAIT_CYCLES edges after the accept edge.
REQ-021 SHALL treat an address as in range when req_addr < DEPTH; the word index is req_addr[log2(DEPTH)-1:0].
REQ-022 SHALL, for an in-range load, drive resp_rdata with mem[index] and resp_err=0.
REQ-023 SHALL, for an in-range store, write mem[index] with wdata on the RESP-entry edge, and drive resp_rdata=0 and resp_err=0.
REQ-024 SHALL, for an out-of-range access, perform no write and drive resp_rdata=0 and resp_err=1.
REQ-025 SHALL hold resp_valid, resp_rdata, and resp_err stable in RESP until resp_ready=1; on that edge it SHALL go RESP->IDLE.
REQ-026 SHALL raise req_ready on the cycle after the response handshake (no same-cycle turnaround); at least 2+WAIT_CYCLES cycles therefore separate accepts.
REQ-027 SHALL ignore req_valid outside IDLE and SHALL NOT queue such requests.
REQ-028 SHALL ignore resp_ready outside RESP.
REQ-029 SHALL increment acc_cnt on each response handshake and saturate it at 16'hFFFF.
REQ-030 SHALL make a load to the same address after a completed store return the stored data (read-after-write coherent).

Reset
REQ-031 SHALL, with reset=1 at an edge, force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, acc_cnt=0, and wait counter=0.
REQ-032 SHALL, on reset during WAIT, abort the pending access; a pending store SHALL NOT be written.
REQ-033 SHALL, on reset during RESP, discard the response; a store already committed on RESP entry SHALL remain in memory.
REQ-034 SHALL NOT clear memory contents on reset; memory SHALL be initialised only by $readmemh or the bench.
REQ-035 SHALL give reset priority over all handshakes in the same cycle.

Verification
REQ-036 SHALL verify: WAIT_CYCLES=2; store addr=5, data=32'hDEADBEEF; resp_ready=1 -> resp_valid rises 3 edges after accept, resp_err=0, and acc_cnt=1.
REQ-037 SHALL verify: load addr=5 after REQ-036 -> resp_rdata=32'hDEADBEEF, resp_err=0, and acc_cnt=2.
REQ-038 SHALL verify: load addr=1024 with DEPTH=1024 -> resp_err=1, resp_rdata=0, and memory unchanged.
REQ-039 SHALL verify: load issued, resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata remain stable, and req_ready stays 0 until 1 cycle after resp_ready=1.
REQ-040 SHALL verify: store addr=7, data=32'h1234; reset asserted 1 cycle after accept (in WAIT) -> a subsequent load of addr=7 returns its prior value, and acc_cnt=0.
REQ-041 SHALL verify: WAIT_CYCLES=0; back-to-back loads with req_valid held high -> resp_valid 1 edge after each accept, and accepts spaced exactly 2 cycles.
